// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths and writeback requester IDs.
//   XLEN     integer datapath width
//   RAW      register address width
//   wb_src_e writeback source IDs, used to decode wr_src
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
    typedef enum logic [2:0] {
        SRC_ALU = 3'd0,
        SRC_LSU = 3'd1,
        SRC_FPU = 3'd2
    } wb_src_e;
endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  in   N    request vector
//   ptr  in   PW   highest-priority index this cycle
//   gnt  out  N    one-hot grant
//   idx  out  PW   index of the granted request
//   any  out  1    some request was granted
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    // Scan from the farthest slot back toward ptr so the nearest request wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = PW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of the integer RF write port.
//   clk, rst       clock, async active-high reset
//   req_valid      per-requester result pending
//   req_rd         per-requester dest reg, [i*RAW +: RAW]
//   req_data       per-requester result, [i*XLEN +: XLEN]
//   req_ready      combinational accept
//   wr_en/addr/data/src  registered RF write, one cycle after accept
//   conflict_cnt   saturating count of cycles with a stalled live request
module wb_port_arbiter #(
    parameter int NREQ  = 3,
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int RAW   = cpu_pkg::RAW,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*RAW-1:0]  req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [RAW-1:0]       wr_addr,
    output logic [XLEN-1:0]      wr_data,
    output logic [2:0]           wr_src,
    output logic [CNT_W-1:0]     conflict_cnt
);
    import cpu_pkg::*;

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]  live, x0, gnt;
    logic [PW-1:0]    idx, rr_ptr_q, rr_ptr_d;
    logic             any;
    logic             wr_en_q, wr_en_d;
    logic [RAW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]  wr_data_q, wr_data_d;
    logic [2:0]       wr_src_q, wr_src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Writes to x0 are acked and dropped without touching the grant.
    always_comb begin
        live = '0;
        x0   = '0;
        for (int i = 0; i < NREQ; i++) begin
            live[i] = req_valid[i] & (|req_rd[i*RAW +: RAW]);
            x0[i]   = req_valid[i] & ~(|req_rd[i*RAW +: RAW]);
        end
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (live),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        req_ready = x0 | gnt;
        rr_ptr_d  = any ? ((idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1)) : rr_ptr_q;
        wr_en_d   = any;
        wr_addr_d = any ? req_rd[idx*RAW +: RAW] : wr_addr_q;
        wr_data_d = any ? req_data[idx*XLEN +: XLEN] : wr_data_q;
        wr_src_d  = any ? 3'(idx) : wr_src_q;
        cnt_d     = ((|(live & ~gnt)) && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= SRC_ALU;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_src       = wr_src_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_rd = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready, s_ready;
    logic        wr_en, s_en;
    logic [4:0]  wr_addr, s_addr;
    logic [31:0] wr_data, s_data;
    logic [2:0]  wr_src, s_src;
    logic [15:0] conflict_cnt;
    logic [3:0]  s_cnt;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NREQ(3), .XLEN(32), .RAW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_src(wr_src), .conflict_cnt(conflict_cnt)
    );

    wb_port_arbiter #(.NREQ(3), .XLEN(32), .RAW(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(s_ready), .wr_en(s_en), .wr_addr(s_addr), .wr_data(s_data),
        .wr_src(s_src), .conflict_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]         = v;
        req_rd[i*5 +: 5]     = rd;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitors: one live grant per cycle, no write to x0, bounded wait.
    logic [2:0] live_m;
    int wait_cnt [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) live_m[i] = req_valid[i] && (req_rd[i*5 +: 5] != 5'd0);
        if (rst) begin
            for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        end else begin
            check("one_live_grant", 64'($countones(req_ready & live_m) <= 1), 64'd1);
            check("no_x0_write", 64'(!(wr_en && wr_addr == 5'd0)), 64'd1);
            for (int i = 0; i < 3; i++) begin
                wait_cnt[i] = (live_m[i] && !req_ready[i]) ? wait_cnt[i] + 1 : 0;
                check("fairness", 64'(wait_cnt[i] < 3), 64'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d [3];
    int w;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cnt", conflict_cnt, 0);
        rst = 1'b0;

        // Single request, rr_ptr -> 1
        set_req(0, 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("single_ready", req_ready, 3'b001);
        cyc();
        check("single_en", wr_en, 1);
        check("single_addr", wr_addr, 5);
        check("single_data", wr_data, 32'hDEADBEEF);
        check("single_src", wr_src, SRC_ALU);
        set_req(0, 0, 0, 0);
        cyc();
        check("idle_en", wr_en, 0);
        check("idle_addr_hold", wr_addr, 5);
        check("idle_data_hold", wr_data, 32'hDEADBEEF);

        // x0 drop with rr_ptr = 1
        set_req(1, 1, 5'd0, 32'h11111111);
        set_req(2, 1, 5'd7, 32'h00000077);
        @(negedge clk);
        check("x0_ready", req_ready, 3'b110);
        cyc();
        check("x0_en", wr_en, 1);
        check("x0_addr", wr_addr, 7);
        check("x0_data", wr_data, 32'h77);
        check("x0_src", wr_src, SRC_FPU);
        check("x0_cnt", conflict_cnt, 0);
        set_req(1, 0, 0, 0);
        set_req(2, 0, 0, 0);

        // Contention from rr_ptr = 0: grants 0,1,2,0,1,2
        for (int i = 0; i < 3; i++) d[i] = 32'h100 + 32'(i);
        for (int k = 0; k < 6; k++) begin
            w = k % 3;
            for (int i = 0; i < 3; i++) set_req(i, 1, 5'(i + 1), d[i]);
            @(negedge clk);
            check("cont_ready", req_ready, 64'(1 << w));
            cyc();
            check("cont_en", wr_en, 1);
            check("cont_src", wr_src, 64'(w));
            check("cont_addr", wr_addr, 64'(w + 1));
            check("cont_data", wr_data, d[w]);
            check("cont_cnt", conflict_cnt, 64'(k + 1));
            d[w] = d[w] + 32'h10;
        end
        for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0);

        // Hold/stall: req1 loses once, then goes with its original data
        set_req(0, 1, 5'd9, 32'h00001111);
        set_req(1, 1, 5'd10, 32'h0000ABCD);
        @(negedge clk);
        check("stall_ready0", req_ready, 3'b001);
        cyc();
        check("stall_src0", wr_src, SRC_ALU);
        check("stall_addr0", wr_addr, 9);
        check("stall_cnt0", conflict_cnt, 7);
        set_req(0, 0, 0, 0);
        @(negedge clk);
        check("stall_ready1", req_ready, 3'b010);
        cyc();
        check("stall_en1", wr_en, 1);
        check("stall_src1", wr_src, SRC_LSU);
        check("stall_addr1", wr_addr, 10);
        check("stall_data1", wr_data, 32'hABCD);
        check("stall_cnt1", conflict_cnt, 7);
        set_req(1, 0, 0, 0);

        // Mid-cycle async reset while wr_en=1 (rr_ptr was 2)
        #2 rst = 1'b1;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_wr_src", wr_src, 0);
        check("arst_cnt", conflict_cnt, 0);
        check("arst_sat_cnt", s_cnt, 0);
        cyc();
        rst = 1'b0;

        // rr_ptr back at 0, then saturate the 4-bit counter
        for (int i = 0; i < 3; i++) set_req(i, 1, 5'(i + 1), 32'h200 + 32'(i));
        @(negedge clk);
        check("post_rst_ready", req_ready, 3'b001);
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k == 14) check("sat_at15", s_cnt, 4'hF);
        end
        check("sat_hold", s_cnt, 4'hF);
        check("wide_cnt", conflict_cnt, 20);
        for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
